// File: rtl/multichannel_iserdes_edge_counter_if.sv
// Control and result bundle for the multichannel ISERDES edge counter.
// master drives window control and sample words; slave returns totals.
interface multichannel_iserdes_edge_counter_if #(
   parameter int NUM_CHANNELS  = 4,
   parameter int BIT_DEPTH     = 8,
   parameter int COUNTER_WIDTH = 32,
   parameter int GATE_WIDTH    = 24
);
   logic                                  enable;
   logic                                  continuous;
   logic [1:0]                            edge_mode;
   logic [GATE_WIDTH-1:0]                 gate_cycles;
   logic [NUM_CHANNELS*BIT_DEPTH-1:0]     in;
   logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] counts;
   logic [NUM_CHANNELS-1:0]               saturated;
   logic                                  valid;
   logic                                  busy;

   modport master (
      output enable, continuous, edge_mode, gate_cycles, in,
      input  counts, saturated, valid, busy
   );

   modport slave (
      input  enable, continuous, edge_mode, gate_cycles, in,
      output counts, saturated, valid, busy
   );
endinterface

// File: rtl/multichannel_iserdes_edge_counter.sv
// Gated per-channel edge counter over deserialized sample words.
// Windows are single-shot or back-to-back; totals saturate, never wrap.
module multichannel_iserdes_edge_counter #(
   parameter int NUM_CHANNELS  = 4,
   parameter int BIT_DEPTH     = 8,
   parameter int COUNTER_WIDTH = 32,
   parameter int GATE_WIDTH    = 24
) (
   input logic clock,
   input logic reset,
   multichannel_iserdes_edge_counter_if.slave bus
);
   localparam int EW = $clog2(BIT_DEPTH + 1);
   localparam int CW = COUNTER_WIDTH;
   localparam int NC = NUM_CHANNELS;

   typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

   state_t                state_q, state_d;
   logic                  last;
   logic                  run;
   logic [GATE_WIDTH-1:0] window_q;
   logic [GATE_WIDTH-1:0] gate_load;
   logic [NC-1:0]         prev_q;
   logic [CW-1:0]         acc_q [NC];
   logic [NC-1:0]         ovf_q;
   logic [EW-1:0]         wc [NC];
   logic [CW:0]           sum [NC];
   logic [CW-1:0]         sat_val [NC];
   logic [NC-1:0]         carry;
   logic [NC*CW-1:0]      counts_q;
   logic [NC-1:0]         saturated_q;
   logic                  valid_q;

   // Edges in one word, earliest sample first, seeded by the prior word.
   function automatic logic [EW-1:0] word_edges(
      input logic                 p,
      input logic [BIT_DEPTH-1:0] w,
      input logic [1:0]           m
   );
      logic [EW-1:0] n;
      logic          a;
      n = '0;
      a = p;
      for (int k = BIT_DEPTH - 1; k >= 0; k--) begin
         if (m != 2'b01 && !a && w[k])
            n = n + EW'(1);
         if ((m == 2'b01 || m == 2'b10) && a && !w[k])
            n = n + EW'(1);
         a = w[k];
      end
      return n;
   endfunction

   assign gate_load = (bus.gate_cycles == '0) ?
                      GATE_WIDTH'(1) : bus.gate_cycles;

   // Per-channel word count and saturating next accumulator value.
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         wc[c]      = word_edges(prev_q[c],
                                 bus.in[c*BIT_DEPTH +: BIT_DEPTH],
                                 bus.edge_mode);
         sum[c]     = {1'b0, acc_q[c]} + (CW+1)'(wc[c]);
         carry[c]   = sum[c][CW];
         sat_val[c] = carry[c] ? {CW{1'b1}} : sum[c][CW-1:0];
      end
   end

   // Window sequencing: next state plus final-word and counting strobes.
   always_comb begin
      state_d = state_q;
      last    = 1'b0;
      run     = 1'b0;
      unique case (state_q)
         IDLE:  if (bus.enable) state_d = ARM;
         ARM:   state_d = COUNT;
         COUNT: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else begin
               run = 1'b1;
               if (window_q == GATE_WIDTH'(1)) begin
                  last = 1'b1;
                  if (!bus.continuous) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Accumulators, window counter and latched results.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_q      <= '0;
         ovf_q       <= '0;
         window_q    <= '0;
         counts_q    <= '0;
         saturated_q <= '0;
         valid_q     <= 1'b0;
         for (int c = 0; c < NC; c++) acc_q[c] <= '0;
      end else begin
         valid_q <= 1'b0;
         for (int c = 0; c < NC; c++)
            prev_q[c] <= bus.in[c*BIT_DEPTH];
         if (state_q == ARM || last) begin
            window_q <= gate_load;
            ovf_q    <= '0;
            for (int c = 0; c < NC; c++) acc_q[c] <= '0;
         end else if (run) begin
            window_q <= window_q - GATE_WIDTH'(1);
            ovf_q    <= ovf_q | carry;
            for (int c = 0; c < NC; c++) acc_q[c] <= sat_val[c];
         end
         if (last) begin
            valid_q     <= 1'b1;
            saturated_q <= ovf_q | carry;
            for (int c = 0; c < NC; c++)
               counts_q[c*CW +: CW] <= sat_val[c];
         end
      end
   end

   assign bus.counts    = counts_q;
   assign bus.saturated = saturated_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_multichannel_iserdes_edge_counter.sv
// Self-checking bench for the multichannel ISERDES edge counter.
// Table-driven windows, continuous random windows, abort and reset.
module tb_multichannel_iserdes_edge_counter;
   localparam int NC   = 4;
   localparam int BD   = 8;
   localparam int CW   = 8;
   localparam int GW   = 24;
   localparam int MAXC = (1 << CW) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;

   multichannel_iserdes_edge_counter_if #(
      .NUM_CHANNELS(NC), .BIT_DEPTH(BD),
      .COUNTER_WIDTH(CW), .GATE_WIDTH(GW)
   ) bus ();

   multichannel_iserdes_edge_counter #(
      .NUM_CHANNELS(NC), .BIT_DEPTH(BD),
      .COUNTER_WIDTH(CW), .GATE_WIDTH(GW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]       mode;
      int               gate;
      logic [NC*BD-1:0] pat;
      int               e0, e1, e2, e3;
      logic             s0;
   } vec_t;

   vec_t             tbl [6];
   int               n_chk  = 0;
   int               n_fail = 0;
   logic [NC*BD-1:0] pat_w;
   logic [NC*BD-1:0] seed_w;
   logic [NC*CW-1:0] exp_cnt_v;
   logic [NC-1:0]    exp_sat_v;
   bit               alt;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference: serialise prev bit then MSB..LSB and count transitions.
   function automatic int edges_of(input logic p, input logic [BD-1:0] w,
                                   input logic [1:0] m);
      int s [BD+1];
      int r, f;
      r = 0;
      f = 0;
      s[0] = int'(p);
      for (int i = 0; i < BD; i++) s[i+1] = int'(w[BD-1-i]);
      for (int i = 0; i < BD; i++) begin
         if (s[i+1] > s[i]) r++;
         if (s[i+1] < s[i]) f++;
      end
      case (m)
         2'b01:   return f;
         2'b10:   return r + f;
         default: return r;
      endcase
   endfunction

   function automatic logic [NC*BD-1:0] gen(input int kind);
      logic [NC*BD-1:0] w;
      w = '0;
      if (kind == 0) begin
         w = pat_w;
      end else if (kind == 1) begin
         w[BD-1:0] = alt ? 8'h0F : 8'h00;
      end else begin
         for (int c = 0; c < NC; c++) w[c*BD +: BD] = BD'($urandom);
      end
      return w;
   endfunction

   task automatic start(input int g, input logic [1:0] m, input bit cont,
                        input logic [NC*BD-1:0] armw);
      bus.gate_cycles = GW'(g);
      bus.edge_mode   = m;
      bus.continuous  = cont;
      bus.enable      = 1'b1;
      bus.in          = armw;
      tick();
      tick();
      seed_w = armw;
   endtask

   task automatic count_window(input int g, input logic [1:0] m,
                               input int kind, input int ng,
                               input string tag);
      int unsigned      acc [NC];
      int               geff;
      int               early;
      int               e;
      logic [NC*BD-1:0] w;
      geff  = (g == 0) ? 1 : g;
      early = 0;
      bus.edge_mode = m;
      for (int c = 0; c < NC; c++) acc[c] = 0;
      for (int i = 0; i < geff; i++) begin
         if (i == 0 && ng >= 0) bus.gate_cycles = GW'(ng);
         w = gen(kind);
         if (kind == 1) alt = !alt;
         bus.in = w;
         for (int c = 0; c < NC; c++)
            acc[c] += edges_of(seed_w[c*BD], w[c*BD +: BD], m);
         seed_w = w;
         tick();
         if (i < geff - 1 && bus.valid) early++;
      end
      chk({tag, " early valid"}, early, 0);
      chk({tag, " valid"}, bus.valid, 1);
      for (int c = 0; c < NC; c++) begin
         e = (acc[c] > MAXC) ? MAXC : int'(acc[c]);
         exp_cnt_v[c*CW +: CW] = CW'(e);
         exp_sat_v[c]          = (acc[c] > MAXC);
         chk($sformatf("%s count ch%0d", tag, c),
             bus.counts[c*CW +: CW], e);
         chk($sformatf("%s sat ch%0d", tag, c),
             bus.saturated[c], exp_sat_v[c]);
      end
   endtask

   task automatic stop_and_idle(input string tag);
      int extra;
      extra = 0;
      bus.enable = 1'b0;
      repeat (3) begin
         tick();
         if (bus.valid) extra++;
      end
      chk({tag, " single pulse"}, extra, 0);
      chk({tag, " idle busy"}, bus.busy, 0);
   endtask

   initial begin
      int g_cur, ng;
      tbl[0] = '{2'b00, 10,  32'h0FFF0055, 40,  0, 0, 10, 1'b0};
      tbl[1] = '{2'b01, 10,  32'h0FFF0055, 40,  0, 0, 10, 1'b0};
      tbl[2] = '{2'b10, 10,  32'h0FFF0055, 80,  0, 0, 20, 1'b0};
      tbl[3] = '{2'b00, 0,   32'h00000055, 4,   0, 0, 0,  1'b0};
      tbl[4] = '{2'b00, 100, 32'h00000055, 255, 0, 0, 0,  1'b1};
      tbl[5] = '{2'b00, 10,  32'h00000055, 40,  0, 0, 0,  1'b0};

      bus.enable      = 1'b0;
      bus.continuous  = 1'b0;
      bus.edge_mode   = 2'b00;
      bus.gate_cycles = '0;
      bus.in          = '0;
      alt             = 1'b0;
      repeat (3) tick();
      chk("reset counts", bus.counts, 0);
      chk("reset saturated", bus.saturated, 0);
      chk("reset valid", bus.valid, 0);
      chk("reset busy", bus.busy, 0);
      #2 reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         pat_w = tbl[i].pat;
         start(tbl[i].gate, tbl[i].mode, 1'b0, pat_w);
         chk($sformatf("t%0d busy", i), bus.busy, 1);
         count_window(tbl[i].gate, tbl[i].mode, 0, -1,
                      $sformatf("t%0d", i));
         chk($sformatf("t%0d tbl ch0", i), bus.counts[0*CW +: CW], tbl[i].e0);
         chk($sformatf("t%0d tbl ch1", i), bus.counts[1*CW +: CW], tbl[i].e1);
         chk($sformatf("t%0d tbl ch2", i), bus.counts[2*CW +: CW], tbl[i].e2);
         chk($sformatf("t%0d tbl ch3", i), bus.counts[3*CW +: CW], tbl[i].e3);
         chk($sformatf("t%0d tbl sat0", i), bus.saturated[0], tbl[i].s0);
         stop_and_idle($sformatf("t%0d", i));
      end

      alt = 1'b0;
      start(4, 2'b00, 1'b1, '0);
      alt = 1'b1;
      count_window(4, 2'b00, 1, -1, "cont w0");
      chk("cont w0 ch0", bus.counts[CW-1:0], 2);
      count_window(4, 2'b00, 1, 6, "cont w1");
      chk("cont w1 ch0", bus.counts[CW-1:0], 2);
      count_window(6, 2'b00, 1, -1, "cont w2");
      chk("cont w2 ch0", bus.counts[CW-1:0], 3);
      g_cur = 6;
      for (int k = 0; k < 8; k++) begin
         ng = $urandom_range(0, 7);
         count_window(g_cur, 2'($urandom_range(0, 3)), 2, ng,
                      $sformatf("rnd%0d", k));
         g_cur = ng;
      end
      bus.enable = 1'b0;
      bus.in     = gen(2);
      tick();
      chk("cont abort valid", bus.valid, 0);
      chk("cont abort busy", bus.busy, 0);

      pat_w = 32'h00000055;
      start(10, 2'b00, 1'b0, pat_w);
      repeat (4) tick();
      bus.enable = 1'b0;
      tick();
      chk("abort valid", bus.valid, 0);
      chk("abort busy", bus.busy, 0);
      repeat (2) tick();
      chk("abort counts hold", bus.counts, exp_cnt_v);
      chk("abort sat hold", bus.saturated, exp_sat_v);
      pat_w = 32'h0FFF0055;
      start(10, 2'b10, 1'b0, pat_w);
      count_window(10, 2'b10, 0, -1, "post abort");
      chk("post abort ch0", bus.counts[CW-1:0], 80);
      stop_and_idle("post abort");

      start(10, 2'b00, 1'b0, pat_w);
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      chk("async rst counts", bus.counts, 0);
      chk("async rst sat", bus.saturated, 0);
      chk("async rst valid", bus.valid, 0);
      chk("async rst busy", bus.busy, 0);
      bus.enable = 1'b0;
      #2 reset = 1'b0;
      tick();
      chk("after rst busy", bus.busy, 0);
      chk("after rst valid", bus.valid, 0);
      start(0, 2'b00, 1'b0, pat_w);
      count_window(0, 2'b00, 0, -1, "after rst");
      chk("after rst ch3", bus.counts[3*CW +: CW], 1);
      stop_and_idle("after rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
